// File: rtl/kernel_loader_pkg.sv
// cnn_kernel_pkg: shared defaults, size helpers and FSM encoding for the kernel loader
package cnn_kernel_pkg;
  localparam int DW_DEF = 8;
  localparam int K_DEF = 3;
  function automatic int taps_of(input int k);
    return k * k;
  endfunction
  function automatic int clog2c(input int n);
    int r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  typedef enum logic [1:0] {IDLE, FETCH, LAST} state_t;
endpackage

// File: rtl/kernel_loader_if.sv
// kernel_loader_if: load request, ROM read port, swap control and active kernel outputs
// slave = loader side, master = controller/ROM/MAC side
interface kernel_loader_if #(
  parameter int DW = 8,
  parameter int K = 3,
  parameter int IW = 7,
  parameter int AW = 10
);
  localparam int TAPS = K * K;
  logic load_req;
  logic [IW-1:0] load_idx;
  logic load_ready;
  logic mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic swap;
  logic [TAPS*DW-1:0] kernel_flat;
  logic kernel_valid;
  logic shadow_full;
  logic load_done;
  logic idx_err;
  modport slave (
    input load_req, load_idx, mem_rdata, swap,
    output load_ready, mem_en, mem_addr, kernel_flat, kernel_valid, shadow_full, load_done, idx_err
  );
  modport master (
    output load_req, load_idx, mem_rdata, swap,
    input load_ready, mem_en, mem_addr, kernel_flat, kernel_valid, shadow_full, load_done, idx_err
  );
endinterface

// File: rtl/kernel_loader_tap_bank.sv
// kernel_tap_bank: TAPS x DW register array with async clear, indexed write and parallel load
// ports: clk, rst (async, active-low), we/waddr/wdata tap write, ld/ld_data whole-bank load, q flat read
module kernel_tap_bank #(
  parameter int DW = 8,
  parameter int TAPS = 9,
  parameter int AW = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic ld,
  input  logic [TAPS*DW-1:0] ld_data,
  output logic [TAPS*DW-1:0] q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= '0;
    else if (ld) q <= ld_data;
    else if (we) q[waddr*DW +: DW] <= wdata;
endmodule

// File: rtl/kernel_loader.sv
// kernel_loader: fetches one K*K kernel from the weight ROM into a shadow bank, commits it to the active bank on swap
// ports: clk, rst (async, active-low), bus (kernel_loader_if.slave: load request, ROM port, swap, active kernel)
module kernel_loader
  import cnn_kernel_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int K = K_DEF,
  parameter int NUM_KERN = 72,
  parameter int IW = 7,
  parameter int AW = 10
) (
  input logic clk,
  input logic rst,
  kernel_loader_if.slave bus
);
  localparam int TAPS = taps_of(K);
  localparam int TW = clog2c(TAPS);
  state_t state;
  logic [TW-1:0] tap;
  logic [TAPS*DW-1:0] shadow_q;
  logic ready, commit, idx_ok, we;
  logic [TW-1:0] waddr;
  assign ready = state == IDLE && (!bus.shadow_full || bus.swap);
  assign commit = bus.swap && bus.shadow_full;
  assign idx_ok = 32'(bus.load_idx) < NUM_KERN;
  // ROM data lags the address by one cycle, so the write slot trails the issued tap
  assign we = state == LAST || (state == FETCH && tap != '0);
  assign waddr = state == LAST ? TW'(TAPS - 1) : tap - 1'b1;
  assign bus.load_ready = ready;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      tap <= '0;
      bus.mem_en <= 1'b0;
      bus.mem_addr <= '0;
      bus.shadow_full <= 1'b0;
      bus.load_done <= 1'b0;
      bus.idx_err <= 1'b0;
      bus.kernel_valid <= 1'b0;
    end else begin
      bus.load_done <= 1'b0;
      bus.idx_err <= 1'b0;
      if (commit) begin
        bus.shadow_full <= 1'b0;
        bus.kernel_valid <= 1'b1;
      end
      case (state)
        IDLE:
          if (bus.load_req && ready) begin
            if (idx_ok) begin
              state <= FETCH;
              tap <= '0;
              bus.mem_en <= 1'b1;
              bus.mem_addr <= AW'(bus.load_idx) * AW'(TAPS);
            end else bus.idx_err <= 1'b1;
          end
        FETCH:
          if (tap == TW'(TAPS - 1)) begin
            state <= LAST;
            bus.mem_en <= 1'b0;
          end else begin
            tap <= tap + 1'b1;
            bus.mem_addr <= bus.mem_addr + 1'b1;
          end
        default: begin
          state <= IDLE;
          bus.shadow_full <= 1'b1;
          bus.load_done <= 1'b1;
        end
      endcase
    end
  kernel_tap_bank #(.DW(DW), .TAPS(TAPS), .AW(TW)) u_shadow (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(bus.mem_rdata),
    .ld(1'b0), .ld_data('0), .q(shadow_q)
  );
  kernel_tap_bank #(.DW(DW), .TAPS(TAPS), .AW(TW)) u_active (
    .clk(clk), .rst(rst), .we(1'b0), .waddr('0), .wdata('0),
    .ld(commit), .ld_data(shadow_q), .q(bus.kernel_flat)
  );
endmodule

// File: tb/tb_kernel_loader.sv
// tb_kernel_loader: scoreboard bench for kernel_loader with a ROM holding ROM[a] = a[7:0]
module tb_kernel_loader;
  localparam int DW = 8, K = 3, NK = 72, IW = 7, AW = 10, TAPS = 9;
  logic clk = 1'b0, rst = 1'b1;
  kernel_loader_if #(.DW(DW), .K(K), .IW(IW), .AW(AW)) bus ();
  kernel_loader #(.DW(DW), .K(K), .NUM_KERN(NK), .IW(IW), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.mem_en) bus.mem_rdata <= bus.mem_addr[7:0];
  int errors = 0, checks = 0;
  int addr_q[$];
  logic [TAPS*DW-1:0] active_m = '0, shadow_m = '0;
  bit full_m = 0, valid_m = 0;

  function automatic logic [TAPS*DW-1:0] kern_of(input int idx);
    logic [TAPS*DW-1:0] k;
    for (int i = 0; i < TAPS; i++) k[i*DW +: DW] = 8'(idx * TAPS + i);
    return k;
  endfunction

  task automatic do_load(input int idx, input bit swap0, input int swap_at);
    int a;
    bit exp_en;
    bus.load_req = 1'b1;
    bus.load_idx = IW'(idx);
    bus.swap = swap0;
    #1;
    if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL accept_ready idx=%0d: got %b want 1", idx, bus.load_ready); end
    checks++;
    for (int t = 0; t < TAPS; t++) addr_q.push_back(idx * TAPS + t);
    if (swap0 && full_m) begin active_m = shadow_m; valid_m = 1; full_m = 0; end
    for (int n = 1; n <= TAPS + 2; n++) begin
      @(negedge clk);
      bus.load_req = 1'b0;
      exp_en = n <= TAPS;
      if (bus.mem_en !== exp_en) begin errors++; $display("FAIL mem_en idx=%0d n=%0d: got %b want %b", idx, n, bus.mem_en, exp_en); end
      checks++;
      if (exp_en) begin
        a = addr_q.size() != 0 ? addr_q.pop_front() : -1;
        if (32'(bus.mem_addr) !== a) begin errors++; $display("FAIL mem_addr idx=%0d n=%0d: got %0d want %0d", idx, n, bus.mem_addr, a); end
        checks++;
      end
      if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL busy_ready idx=%0d n=%0d: got %b want 0", idx, n, bus.load_ready); end
      checks++;
      if (bus.load_done !== (n == TAPS + 2) || bus.shadow_full !== (n == TAPS + 2)) begin
        errors++; $display("FAIL done_full idx=%0d n=%0d: got done=%b full=%b want %b", idx, n, bus.load_done, bus.shadow_full, n == TAPS + 2);
      end
      checks++;
      if (bus.kernel_flat !== active_m || bus.kernel_valid !== valid_m || bus.idx_err !== 1'b0) begin
        errors++; $display("FAIL active_stable idx=%0d n=%0d: got %h v=%b e=%b want %h v=%b e=0", idx, n, bus.kernel_flat, bus.kernel_valid, bus.idx_err, active_m, valid_m);
      end
      checks++;
      bus.swap = n == swap_at;
    end
    shadow_m = kern_of(idx);
    full_m = 1;
  endtask

  task automatic do_swap();
    bus.swap = 1'b1;
    if (full_m) begin active_m = shadow_m; valid_m = 1; full_m = 0; end
    @(negedge clk);
    bus.swap = 1'b0;
    if (bus.kernel_flat !== active_m || bus.kernel_valid !== valid_m) begin
      errors++; $display("FAIL swap_active: got %h v=%b want %h v=%b", bus.kernel_flat, bus.kernel_valid, active_m, valid_m);
    end
    checks++;
    if (bus.shadow_full !== 1'b0 || bus.load_done !== 1'b0 || bus.idx_err !== 1'b0) begin
      errors++; $display("FAIL swap_flags: got full=%b done=%b err=%b want 0 0 0", bus.shadow_full, bus.load_done, bus.idx_err);
    end
    checks++;
  endtask

  task automatic test_reset();
    bus.load_req = 1'b0;
    bus.load_idx = '0;
    bus.swap = 1'b0;
    #1 rst = 1'b0;
    #3;
    if ({bus.mem_en, bus.mem_addr, bus.kernel_valid, bus.shadow_full, bus.load_done, bus.idx_err} !== '0 || bus.kernel_flat !== '0) begin
      errors++; $display("FAIL reset_outputs: got en=%b addr=%0d v=%b f=%b d=%b e=%b k=%h want all 0", bus.mem_en, bus.mem_addr, bus.kernel_valid, bus.shadow_full, bus.load_done, bus.idx_err, bus.kernel_flat);
    end
    checks++;
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_load();
    do_load(0, 0, 0);
    do_swap();
    if (bus.kernel_flat !== 72'h080706050403020100) begin errors++; $display("FAIL kernel0_taps: got %h want 080706050403020100", bus.kernel_flat); end
    checks++;
  endtask

  task automatic test_top_index();
    do_load(71, 0, 0);
    do_swap();
    if ($signed(bus.kernel_flat[7:0]) !== 8'sd127 || $signed(bus.kernel_flat[15:8]) !== -8'sd128 || $signed(bus.kernel_flat[71:64]) !== -8'sd121) begin
      errors++; $display("FAIL kernel71_sign: got %h want 878685848382818 07F", bus.kernel_flat);
    end
    checks++;
  endtask

  task automatic test_idx_err();
    bus.load_req = 1'b1;
    bus.load_idx = IW'(72);
    @(negedge clk);
    bus.load_req = 1'b0;
    if (bus.idx_err !== 1'b1 || bus.mem_en !== 1'b0) begin errors++; $display("FAIL idx_err_pulse: got err=%b en=%b want 1 0", bus.idx_err, bus.mem_en); end
    checks++;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (bus.idx_err !== 1'b0 || bus.mem_en !== 1'b0 || bus.shadow_full !== 1'b0 || bus.kernel_flat !== active_m) begin
        errors++; $display("FAIL idx_err_after n=%0d: got err=%b en=%b full=%b want 0 0 0", n, bus.idx_err, bus.mem_en, bus.shadow_full);
      end
      checks++;
    end
  endtask

  task automatic test_hold_and_overlap();
    do_load(5, 0, 0);
    do_swap();
    do_load(6, 0, 0);
    for (int n = 0; n < 3; n++) begin
      bus.load_req = 1'b1;
      bus.load_idx = IW'(9);
      #1;
      if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL full_ready n=%0d: got %b want 0", n, bus.load_ready); end
      checks++;
      @(negedge clk);
      if (bus.mem_en !== 1'b0 || bus.shadow_full !== 1'b1 || bus.kernel_flat !== kern_of(5)) begin
        errors++; $display("FAIL hold_k5 n=%0d: got en=%b full=%b k=%h want 0 1 %h", n, bus.mem_en, bus.shadow_full, bus.kernel_flat, kern_of(5));
      end
      checks++;
    end
    bus.load_req = 1'b0;
    do_load(7, 1, 0);
    if (bus.kernel_flat !== kern_of(6)) begin errors++; $display("FAIL overlap_active: got %h want %h", bus.kernel_flat, kern_of(6)); end
    checks++;
    do_swap();
  endtask

  task automatic test_back_to_back();
    do_load(10, 0, 0);
    do_load(11, 1, 0);
    do_load(12, 1, 0);
    do_swap();
  endtask

  task automatic test_swap_ignored();
    do_swap();
    do_load(20, 0, 4);
    do_swap();
  endtask

  task automatic test_reset_mid_fetch();
    bus.load_req = 1'b1;
    bus.load_idx = IW'(3);
    @(negedge clk);
    bus.load_req = 1'b0;
    repeat (4) @(negedge clk);
    if (bus.mem_en !== 1'b1 || bus.mem_addr !== AW'(31)) begin errors++; $display("FAIL tap4_issue: got en=%b addr=%0d want 1 31", bus.mem_en, bus.mem_addr); end
    checks++;
    #2 rst = 1'b0;
    #1;
    if ({bus.mem_en, bus.mem_addr, bus.kernel_valid, bus.shadow_full, bus.load_done, bus.idx_err} !== '0 || bus.kernel_flat !== '0) begin
      errors++; $display("FAIL midfetch_reset: got en=%b addr=%0d v=%b f=%b k=%h want all 0", bus.mem_en, bus.mem_addr, bus.kernel_valid, bus.shadow_full, bus.kernel_flat);
    end
    checks++;
    active_m = '0;
    valid_m = 0;
    full_m = 0;
    addr_q.delete();
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    do_load(2, 0, 0);
    do_swap();
  endtask

  initial begin
    test_reset();
    test_first_load();
    test_top_index();
    test_idx_err();
    test_hold_and_overlap();
    test_back_to_back();
    test_swap_ignored();
    test_reset_mid_fetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
